// File: rtl/lpddr4_dfi_cmd_decoder.sv
// PHY-side LPDDR4 DFI command receiver: pairs 4-phase CS/CA ticks, merges
// multi-part commands and queues whole decoded commands behind valid/ready.
module lpddr4_dfi_cmd_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dfi_p0_cs,
  input  logic        dfi_p1_cs,
  input  logic        dfi_p2_cs,
  input  logic        dfi_p3_cs,
  input  logic [5:0]  dfi_p0_ca,
  input  logic [5:0]  dfi_p1_ca,
  input  logic [5:0]  dfi_p2_ca,
  input  logic [5:0]  dfi_p3_ca,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_type,
  output logic [2:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        cmd_flag,
  output logic [5:0]  cmd_ma,
  output logic [7:0]  cmd_op,
  output logic        err_seq,
  output logic        err_ovf,
  output logic [15:0] err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] T_ACT = 4'd0, T_RD  = 4'd1, T_WR  = 4'd2, T_MWR = 4'd3,
                         T_PRE = 4'd4, T_REF = 4'd5, T_MRW = 4'd6, T_MRR = 4'd7,
                         T_SRE = 4'd8, T_SRX = 4'd9, T_MPC = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACT2, S_WAIT_CAS2, S_WAIT_MRW2} seq_state_e;
  typedef enum logic [2:0] {K_BAD, K_SINGLE, K_ACT1, K_ACT2, K_CAS1, K_CAS2, K_MRW1, K_MRW2} part_e;

  typedef struct packed {
    logic [3:0]  ctype;
    logic [2:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic        flag;
    logic [5:0]  ma;
    logic [7:0]  op;
  } cmd_t;

  typedef struct packed { part_e kind; cmd_t cmd; } part_t;
  typedef struct packed { seq_state_e st; cmd_t pend; logic emit; cmd_t cmd; logic err; } step_t;

  // Each part carries only its own fields, so merging parts is a plain OR.
  function automatic part_t decode_pair(input logic [5:0] c1, input logic [5:0] c2);
    part_t p;
    p = '0;
    p.kind = K_BAD;
    if (c1[1:0] == 2'b01) begin
      p.kind = K_ACT1;         p.cmd.ctype = T_ACT;
      p.cmd.row[15:12] = c1[5:2]; p.cmd.row[11:10] = c2[5:4]; p.cmd.bank = c2[2:0];
    end else if (c1[1:0] == 2'b11) begin
      p.kind = K_ACT2;
      p.cmd.row[9:6] = c1[5:2];   p.cmd.row[5:0] = c2;
    end else begin
      case (c1[4:0])
        5'b00000: begin p.kind = K_SINGLE; p.cmd.ctype = T_MPC; p.cmd.op = {1'b0, c1[5], c2}; end
        5'b00110: begin p.kind = K_MRW1; p.cmd.ctype = T_MRW; p.cmd.op[7] = c1[5]; p.cmd.ma = c2; end
        5'b10110: begin p.kind = K_MRW2; p.cmd.op[6] = c1[5]; p.cmd.op[5:0] = c2; end
        5'b01110: begin p.kind = K_CAS1; p.cmd.ctype = T_MRR; p.cmd.flag = c1[5]; p.cmd.ma = c2; end
        5'b00100, 5'b01100, 5'b00010: begin
          p.kind = K_CAS1;
          p.cmd.ctype = (c1[4:0] == 5'b00100) ? T_WR : (c1[4:0] == 5'b01100) ? T_MWR : T_RD;
          p.cmd.bank = c2[2:0]; p.cmd.col[9] = c2[4]; p.cmd.flag = c2[5];
        end
        5'b10010: begin p.kind = K_CAS2; p.cmd.col[8] = c1[5]; p.cmd.col[7:2] = c2; end
        5'b10000, 5'b01000: begin
          p.kind = K_SINGLE; p.cmd.ctype = c1[4] ? T_PRE : T_REF;
          p.cmd.flag = c1[5]; p.cmd.bank = c2[2:0];
        end
        5'b11000: begin p.kind = K_SINGLE; p.cmd.ctype = T_SRE; end
        5'b10100: begin p.kind = K_SINGLE; p.cmd.ctype = T_SRX; end
        default:  p.kind = K_BAD;
      endcase
    end
    return p;
  endfunction

  function automatic step_t seq_step(input seq_state_e st, input cmd_t pend, input part_t p);
    step_t s;
    s = '0;
    if ((st == S_WAIT_ACT2 && p.kind == K_ACT2) || (st == S_WAIT_CAS2 && p.kind == K_CAS2) ||
        (st == S_WAIT_MRW2 && p.kind == K_MRW2)) begin
      s.emit = 1'b1;
      s.st   = S_IDLE;
      s.cmd  = pend | p.cmd;
      if (pend.ctype == T_MRR) s.cmd.col = '0;
    end else begin
      // An interrupted sequence drops the pending part; the new pair starts afresh.
      s.err = (st != S_IDLE);
      s.st  = S_IDLE;
      s.cmd = p.cmd;
      case (p.kind)
        K_SINGLE: s.emit = 1'b1;
        K_ACT1:   begin s.st = S_WAIT_ACT2; s.pend = p.cmd; end
        K_CAS1:   begin s.st = S_WAIT_CAS2; s.pend = p.cmd; end
        K_MRW1:   begin s.st = S_WAIT_MRW2; s.pend = p.cmd; end
        default:  s.err = 1'b1;
      endcase
    end
    return s;
  endfunction

  logic [3:0] w_cs;
  logic [5:0] w_ca [4];
  assign w_cs = {dfi_p3_cs, dfi_p2_cs, dfi_p1_cs, dfi_p0_cs};
  assign w_ca[0] = dfi_p0_ca;
  assign w_ca[1] = dfi_p1_ca;
  assign w_ca[2] = dfi_p2_ca;
  assign w_ca[3] = dfi_p3_ca;

  seq_state_e r_state, w_nxt_state;
  cmd_t       r_pend, w_nxt_pend;
  logic       r_carry_v, w_nxt_carry_v;
  logic [5:0] r_carry_ca, w_nxt_carry_ca;
  logic       w_seq_err;
  logic [1:0] w_n_emit;
  cmd_t       w_emit [2];
  step_t      w_step;

  // Walks the four ticks in order; at most two pairs can complete per cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_nxt_state    = r_state;
    w_nxt_pend     = r_pend;
    w_nxt_carry_v  = r_carry_v;
    w_nxt_carry_ca = r_carry_ca;
    w_seq_err      = 1'b0;
    w_n_emit       = 2'd0;
    w_emit[0]      = '0;
    w_emit[1]      = '0;
    w_step         = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_nxt_carry_v) begin
        if (w_cs[i]) begin
          w_seq_err      = 1'b1;
          w_nxt_carry_ca = w_ca[i];
        end else begin
          // NOTE: blocking assignments here are deliberate -- later ticks must see earlier ticks' results.
          w_step = seq_step(w_nxt_state, w_nxt_pend, decode_pair(w_nxt_carry_ca, w_ca[i]));
          w_nxt_state   = w_step.st;
          w_nxt_pend    = w_step.pend;
          w_seq_err     = w_seq_err | w_step.err;
          w_nxt_carry_v = 1'b0;
          if (w_step.emit) begin
            w_emit[w_n_emit[0]] = w_step.cmd;
            w_n_emit            = w_n_emit + 2'd1;
          end
        end
      end else if (w_cs[i]) begin
        w_nxt_carry_v  = 1'b1;
        w_nxt_carry_ca = w_ca[i];
      end
    end
  end

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_free;
  logic          w_pop, w_push0, w_push1, w_ovf;
  logic [1:0]    w_n_push;
  logic [16:0]   w_cnt_sum;
  logic          r_err_seq, r_err_ovf;
  logic [15:0]   r_err_count;

  assign w_pop     = cmd_valid & cmd_ready;
  assign w_free    = (AW+1)'(FIFO_DEPTH) - r_count + (AW+1)'(w_pop);
  assign w_push0   = (w_n_emit != 2'd0) && (w_free >= (AW+1)'(1));
  assign w_push1   = (w_n_emit == 2'd2) && (w_free >= (AW+1)'(2));
  assign w_n_push  = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_ovf     = (w_n_emit > w_n_push);
  assign w_cnt_sum = {1'b0, r_err_count} + 17'(w_seq_err) + 17'(w_ovf);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_carry_v   <= 1'b0;
      r_carry_ca  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_err_seq   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_pend      <= w_nxt_pend;
      r_carry_v   <= w_nxt_carry_v;
      r_carry_ca  <= w_nxt_carry_ca;
      r_wptr      <= r_wptr + AW'(w_n_push);
      r_rptr      <= r_rptr + AW'(w_pop);
      r_count     <= r_count + (AW+1)'(w_n_push) - (AW+1)'(w_pop);
      r_err_seq   <= w_seq_err;
      r_err_ovf   <= w_ovf;
      r_err_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  // NOTE: storage has no reset; r_count gates visibility, so stale entries are never presented.
  always_ff @(posedge sys_clk) begin
    if (w_push0) r_mem[r_wptr] <= w_emit[0];
    if (w_push1) r_mem[r_wptr + AW'(1)] <= w_emit[1];
  end

  cmd_t w_head;
  always_comb begin
    cmd_valid = (r_count != '0);
    w_head    = cmd_valid ? r_mem[r_rptr] : '0;
  end

  assign cmd_type  = w_head.ctype;
  assign cmd_bank  = w_head.bank;
  assign cmd_row   = w_head.row;
  assign cmd_col   = w_head.col;
  assign cmd_flag  = w_head.flag;
  assign cmd_ma    = w_head.ma;
  assign cmd_op    = w_head.op;
  assign err_seq   = r_err_seq;
  assign err_ovf   = r_err_ovf;
  assign err_count = r_err_count;
endmodule

// File: tb/tb_lpddr4_dfi_cmd_decoder.sv
// Scoreboard bench for lpddr4_dfi_cmd_decoder: directed DFI tick vectors push
// expected commands; a negedge monitor pops and compares on each handshake.
module tb_lpddr4_dfi_cmd_decoder;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        dfi_p0_cs, dfi_p1_cs, dfi_p2_cs, dfi_p3_cs;
  logic [5:0]  dfi_p0_ca, dfi_p1_ca, dfi_p2_ca, dfi_p3_ca;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_type;
  logic [2:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_flag;
  logic [5:0]  cmd_ma;
  logic [7:0]  cmd_op;
  logic        err_seq, err_ovf;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;
  logic [47:0] expq[$];

  lpddr4_dfi_cmd_decoder #(.FIFO_DEPTH(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .dfi_p0_cs(dfi_p0_cs), .dfi_p1_cs(dfi_p1_cs), .dfi_p2_cs(dfi_p2_cs), .dfi_p3_cs(dfi_p3_cs),
    .dfi_p0_ca(dfi_p0_ca), .dfi_p1_ca(dfi_p1_ca), .dfi_p2_ca(dfi_p2_ca), .dfi_p3_ca(dfi_p3_ca),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_flag(cmd_flag), .cmd_ma(cmd_ma), .cmd_op(cmd_op),
    .err_seq(err_seq), .err_ovf(err_ovf), .err_count(err_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [3:0] t, input logic [2:0] ba, input logic [15:0] row,
                                     input logic [9:0] col, input logic fl, input logic [5:0] ma,
                                     input logic [7:0] op);
    return {t, ba, row, col, fl, ma, op};
  endfunction

  // Applies one cycle of ticks (bit i of cs is phase i), then returns to DES just after the edge.
  task automatic drive(input logic [3:0] cs, input logic [5:0] a0, input logic [5:0] a1,
                       input logic [5:0] a2, input logic [5:0] a3);
    {dfi_p3_cs, dfi_p2_cs, dfi_p1_cs, dfi_p0_cs} = cs;
    dfi_p0_ca = a0; dfi_p1_ca = a1; dfi_p2_ca = a2; dfi_p3_ca = a3;
    @(posedge sys_clk); #1;
    {dfi_p3_cs, dfi_p2_cs, dfi_p1_cs, dfi_p0_cs} = 4'b0;
    dfi_p0_ca = '0; dfi_p1_ca = '0; dfi_p2_ca = '0; dfi_p3_ca = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0, 6'd0, 6'd0, 6'd0, 6'd0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && expq.size() != 0; i++) idle(1);
    check(name, expq.size(), 0);
  endtask

  initial begin : monitor
    logic [47:0] exp_cmd;
    forever begin
      @(negedge sys_clk);
      if (sys_rst && cmd_valid && cmd_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got type %0d bank %0d with nothing expected", cmd_type, cmd_bank);
        end else begin
          exp_cmd = expq.pop_front();
          check("cmd", {cmd_type, cmd_bank, cmd_row, cmd_col, cmd_flag, cmd_ma, cmd_op}, exp_cmd);
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b0;
    cmd_ready = 1'b1;
    {dfi_p3_cs, dfi_p2_cs, dfi_p1_cs, dfi_p0_cs} = 4'b0;
    dfi_p0_ca = '0; dfi_p1_ca = '0; dfi_p2_ca = '0; dfi_p3_ca = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_outputs", {cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_flag, cmd_ma,
                            cmd_op, err_seq, err_ovf, err_count}, '0);
    sys_rst = 1'b1;
    idle(2);

    // ACT-1 at p2/p3, ACT-2 next cycle p0/p1: row 0xD8C9, bank 5, visible one cycle later.
    drive(4'b0100, 6'd0, 6'd0, 6'b110101, 6'b100101);
    check("act_not_yet", cmd_valid, 1'b0);
    expq.push_back(mk(4'd0, 3'd5, 16'hD8C9, 10'd0, 1'b0, 6'd0, 8'd0));
    drive(4'b0001, 6'b001111, 6'b001001, 6'd0, 6'd0);
    check("act_latency", cmd_valid, 1'b1);
    idle(2);

    // RD-1 split across the cycle boundary, then CAS-2 at p1/p2.
    drive(4'b1000, 6'd0, 6'd0, 6'd0, 6'b000010);
    expq.push_back(mk(4'd1, 3'd2, 16'd0, 10'h254, 1'b1, 6'd0, 8'd0));
    drive(4'b0010, 6'b110010, 6'b010010, 6'b010101, 6'd0);
    idle(2);

    // Two PREs in one cycle, a full MRW, MRR+CAS-2, then MPC and SRX.
    expq.push_back(mk(4'd4, 3'd1, 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
    expq.push_back(mk(4'd4, 3'd0, 16'd0, 10'd0, 1'b1, 6'd0, 8'd0));
    drive(4'b0101, 6'b010000, 6'b000001, 6'b110000, 6'b000000);
    expq.push_back(mk(4'd6, 3'd0, 16'd0, 10'd0, 1'b0, 6'h0d, 8'hAA));
    drive(4'b0101, 6'b100110, 6'h0d, 6'b010110, 6'h2a);
    expq.push_back(mk(4'd7, 3'd0, 16'd0, 10'd0, 1'b1, 6'h05, 8'd0));
    drive(4'b0101, 6'b101110, 6'h05, 6'b010010, 6'd0);
    expq.push_back(mk(4'd10, 3'd0, 16'd0, 10'd0, 1'b0, 6'd0, 8'h51));
    expq.push_back(mk(4'd9, 3'd0, 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
    drive(4'b0101, 6'b100000, 6'h11, 6'b010100, 6'd0);
    check("no_seq_err_yet", err_count, 16'd0);
    drain("drain_basic");

    // Orphan CAS-2, interrupted WR-1, illegal encoding, cs=1 on tick2.
    drive(4'b0001, 6'b010010, 6'd0, 6'd0, 6'd0);
    check("orphan_err_seq", err_seq, 1'b1);
    check("orphan_err_count", err_count, 16'd1);
    idle(1);
    check("err_seq_one_pulse", err_seq, 1'b0);
    check("orphan_no_entry", cmd_valid, 1'b0);
    expq.push_back(mk(4'd4, 3'd3, 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
    drive(4'b0101, 6'b000100, 6'd0, 6'b010000, 6'b000011);
    check("interrupt_err_seq", err_seq, 1'b1);
    check("interrupt_err_count", err_count, 16'd2);
    drive(4'b0001, 6'b011100, 6'd0, 6'd0, 6'd0);
    check("illegal_err_count", err_count, 16'd3);
    expq.push_back(mk(4'd5, 3'd4, 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
    drive(4'b0011, 6'b001000, 6'b001000, 6'b000100, 6'd0);
    check("cs_on_tick2_err_count", err_count, 16'd4);
    drain("drain_errors");

    // Fill with cmd_ready=0: eight REFs fit, the ninth is dropped.
    cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expq.push_back(mk(4'd5, 3'(2*k), 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
      expq.push_back(mk(4'd5, 3'(2*k+1), 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
      drive(4'b0101, 6'b001000, 6'(2*k), 6'b001000, 6'(2*k+1));
      check("fill_no_ovf", err_ovf, 1'b0);
    end
    drive(4'b0001, 6'b101000, 6'd0, 6'd0, 6'd0);
    check("ovf_pulse", err_ovf, 1'b1);
    check("ovf_err_count", err_count, 16'd5);
    check("head_held", {cmd_valid, cmd_type, cmd_bank}, {1'b1, 4'd5, 3'd0});
    cmd_ready = 1'b1;
    expq.push_back(mk(4'd4, 3'd7, 16'd0, 10'd0, 1'b0, 6'd0, 8'd0));
    drive(4'b0001, 6'b010000, 6'b000111, 6'd0, 6'd0);
    check("pop_push_no_ovf", err_ovf, 1'b0);
    drain("drain_full");

    // Reset while in WAIT_MRW2 with a buffered PRE.
    cmd_ready = 1'b0;
    drive(4'b0101, 6'b010000, 6'b000010, 6'b100110, 6'b000011);
    check("pre_buffered", cmd_valid, 1'b1);
    #1 sys_rst = 1'b0;
    #1;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    cmd_ready = 1'b1;
    drive(4'b0001, 6'b010110, 6'h2a, 6'd0, 6'd0);
    check("mrw2_after_rst_err", err_seq, 1'b1);
    check("mrw2_after_rst_count", err_count, 16'd1);
    idle(1);
    check("final_empty", cmd_valid, 1'b0);
    check("final_queue", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
